// File: rtl/fmul_result_pack_if.sv
// Handshake bundle between the multiplier, the result pack stage and its consumer.
// The slave view is the pack stage; the master view drives results in and drains them out.
interface fmul_result_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_frac;
  logic        in_error;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_error;
  logic        out_overflow;

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_error, out_overflow
  );

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_error, out_overflow
  );
endinterface

// File: rtl/fmul_result_pack.sv
// Packs unpacked multiplier results into binary32 words, buffers them in a small FIFO
// and keeps sticky invalid/overflow flags plus saturating event counters.
module fmul_result_pack #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fmul_result_pack_if.slave    bus,
  input  logic                 flag_clear,
  output logic                 flag_invalid,
  output logic                 flag_overflow,
  output logic [CNT_W-1:0]     nan_cnt,
  output logic [CNT_W-1:0]     ovf_cnt,
  output logic [CW-1:0]        count
);

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      data_mem_r [DEPTH];
  logic [DEPTH-1:0] err_mem_r;
  logic [DEPTH-1:0] ovf_mem_r;
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]    count_r, count_next_s;
  logic             in_ready_r, out_valid_r, out_error_r, out_overflow_r;
  logic [31:0]      out_data_r;
  logic             out_error_next_s, out_overflow_next_s;
  logic [31:0]      out_data_next_s, packed_s;
  logic             push_s, pop_s;
  logic             flag_invalid_r, flag_overflow_r, flag_invalid_next_s, flag_overflow_next_s;
  logic [CNT_W-1:0] nan_cnt_r, ovf_cnt_r, nan_cnt_next_s, ovf_cnt_next_s;

  function automatic logic [31:0] pack_result(input logic sign, input logic [7:0] exp,
                                              input logic [23:0] frac, input logic err,
                                              input logic ovf);
    if (err) begin
      return 32'h7FC0_0000;
    end else if (ovf) begin
      return {sign, 8'hFF, 23'h0};
    end else if (exp == 8'h00) begin
      return {sign, 31'h0};
    end else begin
      return {sign, exp, frac[22:0]};
    end
  endfunction

  // Clear wins against an idle event; a coincident event restarts the count at one.
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cur,
                                                  input logic set, input logic clr);
    if (set && clr) begin
      return CNT_W'(1);
    end else if (set) begin
      return (cur == CNT_MAX) ? cur : cur + CNT_W'(1);
    end else if (clr) begin
      return '0;
    end else begin
      return cur;
    end
  endfunction

  // Handshake qualification, occupancy and head-of-queue selection.
  always_comb begin
    push_s          = bus.in_valid & in_ready_r;
    pop_s           = out_valid_r & bus.out_ready;
    packed_s        = pack_result(bus.in_sign, bus.in_exp, bus.in_frac, bus.in_error, bus.in_overflow);
    count_next_s    = count_r;
    rd_next_s       = rd_ptr_r;
    out_data_next_s = out_data_r;
    out_error_next_s    = out_error_r;
    out_overflow_next_s = out_overflow_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + AW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    // The entry written this cycle is the new head only when nothing older remains.
    if (count_next_s == '0) begin
      out_data_next_s = out_data_r;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      out_data_next_s     = packed_s;
      out_error_next_s    = bus.in_error;
      out_overflow_next_s = bus.in_overflow;
    end else begin
      out_data_next_s     = data_mem_r[rd_next_s];
      out_error_next_s    = err_mem_r[rd_next_s];
      out_overflow_next_s = ovf_mem_r[rd_next_s];
    end
    flag_invalid_next_s  = (push_s & bus.in_error) | (flag_invalid_r & ~flag_clear);
    flag_overflow_next_s = (push_s & bus.in_overflow) | (flag_overflow_r & ~flag_clear);
    nan_cnt_next_s = cnt_update(nan_cnt_r, push_s & bus.in_error, flag_clear);
    ovf_cnt_next_s = cnt_update(ovf_cnt_r, push_s & bus.in_overflow, flag_clear);
  end

  // FIFO storage, pointers, registered outputs and exception bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= 32'h0;
      end
      err_mem_r       <= '0;
      ovf_mem_r       <= '0;
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      count_r         <= '0;
      in_ready_r      <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= 32'h0;
      out_error_r     <= 1'b0;
      out_overflow_r  <= 1'b0;
      flag_invalid_r  <= 1'b0;
      flag_overflow_r <= 1'b0;
      nan_cnt_r       <= '0;
      ovf_cnt_r       <= '0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= packed_s;
        err_mem_r[wr_ptr_r]  <= bus.in_error;
        ovf_mem_r[wr_ptr_r]  <= bus.in_overflow;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r        <= rd_next_s;
      count_r         <= count_next_s;
      in_ready_r      <= (count_next_s < DEPTH_C);
      out_valid_r     <= (count_next_s != '0);
      out_data_r      <= out_data_next_s;
      out_error_r     <= out_error_next_s;
      out_overflow_r  <= out_overflow_next_s;
      flag_invalid_r  <= flag_invalid_next_s;
      flag_overflow_r <= flag_overflow_next_s;
      nan_cnt_r       <= nan_cnt_next_s;
      ovf_cnt_r       <= ovf_cnt_next_s;
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_error    = out_error_r;
  assign bus.out_overflow = out_overflow_r;
  assign flag_invalid     = flag_invalid_r;
  assign flag_overflow    = flag_overflow_r;
  assign nan_cnt          = nan_cnt_r;
  assign ovf_cnt          = ovf_cnt_r;
  assign count            = count_r;

endmodule

// File: tb/tb_fmul_result_pack.sv
// Directed test of fmul_result_pack: stimulus queues expected words, a monitor pops and compares.
module tb_fmul_result_pack;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flag_clear;
  logic             flag_invalid, flag_overflow;
  logic [CNT_W-1:0] nan_cnt, ovf_cnt;
  logic [CW-1:0]    count;

  fmul_result_pack_if bus ();

  fmul_result_pack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flag_clear    (flag_clear),
    .flag_invalid  (flag_invalid),
    .flag_overflow (flag_overflow),
    .nan_cnt       (nan_cnt),
    .ovf_cnt       (ovf_cnt),
    .count         (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted output word is compared against the queue head.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'h0, bus.out_error, bus.out_overflow, bus.out_data}, 64'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_word", {30'h0, bus.out_error, bus.out_overflow, bus.out_data}, {30'h0, mon_exp});
      end
    end
  end

  task automatic push_one(input logic s, input logic [7:0] e, input logic [23:0] f,
                          input logic er, input logic ov, input logic [31:0] expd);
    int waited;
    bus.in_sign     = s;
    bus.in_exp      = e;
    bus.in_frac     = f;
    bus.in_error    = er;
    bus.in_overflow = ov;
    bus.in_valid    = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      chk("push_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back({er, ov, expd});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || count != '0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0]  e_i;
    logic [23:0] f_i;
    rst_n = 1'b0;
    flag_clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = 8'h0; bus.in_frac = 24'h0;
    bus.in_error = 1'b0; bus.in_overflow = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_flags", {62'h0, flag_invalid, flag_overflow}, 64'd0);
    chk("rst_counters", {48'h0, nan_cnt, ovf_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(bus.in_ready), 64'd1);

    // Single results with the consumer always ready.
    bus.out_ready = 1'b1;
    push_one(1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 32'h4040_0000);
    chk("latency_valid", 64'(bus.out_valid), 64'd1);
    chk("normal_flags", {62'h0, flag_invalid, flag_overflow}, 64'd0);
    push_one(1'b1, 8'hFF, 24'h800000, 1'b1, 1'b0, 32'h7FC0_0000);
    chk("nan_flag_invalid", 64'(flag_invalid), 64'd1);
    chk("nan_cnt_1", 64'(nan_cnt), 64'd1);
    push_one(1'b1, 8'h80, 24'hABCDEF, 1'b0, 1'b1, 32'hFF80_0000);
    chk("ovf_flag_overflow", 64'(flag_overflow), 64'd1);
    chk("ovf_cnt_1", 64'(ovf_cnt), 64'd1);
    push_one(1'b1, 8'h00, 24'h123456, 1'b0, 1'b0, 32'h8000_0000);
    push_one(1'b1, 8'h7F, 24'hA00000, 1'b0, 1'b0, 32'hBFA0_0000);
    push_one(1'b0, 8'h40, 24'hFFFFFF, 1'b1, 1'b1, 32'h7FC0_0000);
    repeat (3) @(negedge clk);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_out_data_held", 64'(bus.out_data), 64'h7FC0_0000);
    chk("both_counters", {48'h0, nan_cnt, ovf_cnt}, {48'h0, 8'd2, 8'd2});

    // Back-pressure: third result must be held by the source.
    bus.out_ready = 1'b0;
    push_one(1'b0, 8'h81, 24'h900000, 1'b0, 1'b0, 32'h4090_0000);
    push_one(1'b1, 8'h82, 24'hF00000, 1'b0, 1'b0, 32'hC170_0000);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd2);
    bus.in_sign = 1'b0; bus.in_exp = 8'h7E; bus.in_frac = 24'h800000; bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_count", 64'(count), 64'd2);
    chk("held_out_data", 64'(bus.out_data), 64'h4090_0000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_pop", 64'(bus.in_ready), 64'd1);
    chk("count_after_pop", 64'(count), 64'd1);
    push_one(1'b0, 8'h7E, 24'h800000, 1'b0, 1'b0, 32'h3F00_0000);
    drain("drain_backpressure");

    // Sustained simultaneous push and pop at occupancy one.
    bus.out_ready = 1'b0;
    push_one(1'b0, 8'h0F, 24'h800001, 1'b0, 1'b0, 32'h0780_0001);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e_i = 8'h10 + 8'(i);
      f_i = 24'h800000 | 24'(i * 17);
      push_one(1'(i), e_i, f_i, 1'b0, 1'b0, {1'(i), e_i, f_i[22:0]});
      chk("steady_count", 64'(count), 64'd1);
    end
    flag_clear = 1'b1;
    push_one(1'b0, 8'h20, 24'h812345, 1'b1, 1'b0, 32'h7FC0_0000);
    flag_clear = 1'b0;
    chk("clear_set_invalid", 64'(flag_invalid), 64'd1);
    chk("clear_set_nan_cnt", 64'(nan_cnt), 64'd1);
    chk("clear_overflow", 64'(flag_overflow), 64'd0);
    chk("clear_ovf_cnt", 64'(ovf_cnt), 64'd0);
    drain("drain_steady");

    // Counter saturation.
    for (int i = 0; i < 300; i++) begin
      push_one(1'b1, 8'hFF, 24'hC00000, 1'b1, 1'b0, 32'h7FC0_0000);
    end
    chk("nan_cnt_saturated", 64'(nan_cnt), 64'd255);
    drain("drain_saturation");

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    push_one(1'b0, 8'h90, 24'hC00000, 1'b0, 1'b1, 32'hFF80_0000 & 32'h7FFF_FFFF);
    push_one(1'b0, 8'h91, 24'h800000, 1'b0, 1'b0, 32'h4880_0000);
    chk("pre_reset_count", 64'(count), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_flags", {62'h0, flag_invalid, flag_overflow}, 64'd0);
    chk("async_rst_counters", {48'h0, nan_cnt, ovf_cnt}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    push_one(1'b0, 8'h85, 24'hA00000, 1'b0, 1'b0, 32'h42A0_0000);
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/fmul_result_pack.md
Name: fmul_result_pack

Overview:
- Output stage directly downstream of the single-precision multiplier.
- Accepts the unpacked result {sign, exp, frac with hidden bit, error, overflow} through a valid/ready handshake and packs it into an IEEE-754 binary32 word.
- Buffers results in a small FIFO so downstream back-pressure never stalls the multiplier mid-result.
- Keeps sticky invalid/overflow exception flags for the control/status logic.

Parameters:
- DEPTH, 2: FIFO entries. Power of two, at least 2.
- CNT_W, 8: width of the saturating exception-event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  multiplier result valid.
- in_ready  out  1  stage can accept a result.
- in_sign  in  1  result sign.
- in_exp  in  8  biased result exponent.
- in_frac  in  24  result fraction; bit 23 is the hidden bit.
- in_error  in  1  invalid operation (NaN result).
- in_overflow  in  1  exponent overflow.
- out_valid  out  1  packed result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  packed binary32 result.
- out_error  out  1  per-result invalid flag.
- out_overflow  out  1  per-result overflow flag.
- flag_invalid  out  1  sticky invalid flag.
- flag_overflow  out  1  sticky overflow flag.
- flag_clear  in  1  clears both sticky flags.
- nan_cnt  out  CNT_W  saturating count of accepted error results.
- ovf_cnt  out  CNT_W  saturating count of accepted overflow results.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, on rst_n low) clears the FIFO pointers, count, out_valid, out_data, out_error, out_overflow, both sticky flags, nan_cnt and ovf_cnt. All outputs read 0 during reset.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- Pack rules are applied at push time and evaluated in this priority order:
  - in_error: store 32'h7FC00000 (canonical quiet NaN, sign 0). The incoming fraction is discarded.
  - in_overflow: store {in_sign, 8'hFF, 23'h0}, i.e. signed infinity.
  - in_exp == 0: store {in_sign, 31'h0}, i.e. signed zero (flush).
  - Otherwise: store {in_sign, in_exp, in_frac[22:0]}.
- Both in_error and in_overflow set: packed as NaN, and both flags are stored with the entry.
- Latency: a push at edge N produces out_valid=1 at edge N. The result is visible in the cycle after acceptance. There is no empty-FIFO bypass.
- out_data, out_error and out_overflow come from the head entry. They hold stable while out_valid & !out_ready. They keep their last value when the FIFO is empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, a push cannot occur in the same cycle as the pop, because in_ready was already 0.
  - in_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Sticky flags:
  - Set on any accepted push carrying in_error or in_overflow.
  - Cleared by flag_clear.
  - If clear and set occur in the same cycle, set wins.
- nan_cnt and ovf_cnt increment on accepted pushes with the matching flag. They saturate at 2^CNT_W−1. flag_clear also zeroes them; set wins here as well.
- Inputs are ignored when in_ready=0. No overflow or underflow of the FIFO is ever possible.
- Reset asserted mid-transfer discards all buffered entries. The first result after release is accepted with in_ready=1.

Test Plan:
- Normal result: sign=0, exp=128, frac=24'hC00000, push then out_ready=1 → out_data=32'h40400000 one cycle after acceptance; flags stay 0.
- NaN result: in_error=1, sign=1, exp=8'hFF, frac=24'h800000 → out_data=32'h7FC00000, out_error=1, flag_invalid=1, nan_cnt=1.
- Overflow and zero cases:
  - in_overflow=1, sign=1 → out_data=32'hFF800000, flag_overflow=1.
  - sign=1, exp=0 → out_data=32'h80000000.
- Back-pressure with out_ready=0:
  - Push three results with DEPTH=2 → in_ready=0 after the second push; count=2; the third is held by the source.
  - Raise out_ready → results drain in order, and in_ready returns 1 one cycle after the first pop.
- Simultaneous push/pop at count=1, sustained for 10 cycles → count stays 1 and order is preserved. Then assert flag_clear in the same cycle as a NaN push → flag_invalid=1, nan_cnt=1.
- Saturation and reset:
  - 300 NaN pushes with CNT_W=8 → nan_cnt=255.
  - Assert rst_n=0 asynchronously with 2 entries buffered → out_valid, count, flags and counters read 0 immediately, and in_ready=1 after release.
